// File: rtl/forward_hazard_unit_pkg.sv
// Shared definitions for the EX-stage forwarding / load-use hazard unit.
//   REG_W       : register index width
//   ZERO_REG    : index of XZR (never forwarded, never stalls)
//   pipe_meta_t : per-stage destination metadata carried down the shadow pipe
//   is_live     : stage holds a real instruction that writes a real register
package forward_hazard_unit_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regWrite;
        logic             memRead;
    } pipe_meta_t;

    function automatic logic is_live(input pipe_meta_t m);
        return m.valid & m.regWrite & (m.rd != ZERO_REG);
    endfunction

endpackage

// File: rtl/forward_hazard_unit_compare.sv
// Producer/consumer match for one stage against one source index.
//   meta      : producer stage metadata
//   src       : consumer source register index
//   load_only : when set, only a load producer can hit (load-use check)
//   hit       : producer is live and writes the register the consumer reads
module fwd_compare
    import forward_hazard_unit_pkg::*;
(
    input  pipe_meta_t       meta,
    input  logic [REG_W-1:0] src,
    input  logic             load_only,
    output logic             hit
);

    assign hit = is_live(meta) & (meta.rd == src) & (~load_only | meta.memRead);

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding-mux selects and load-use stall for the EX stage of a LEGv8 pipe.
// Keeps ID/EX, EX/MEM and MEM/WB shadow copies of destination metadata and
// compares them against the EX-stage sources (ID/EX rn/rm).
//   clk, reset                : clock, asynchronous active-high reset
//   id_valid/rn/rm/rd         : decode-stage instruction fields
//   id_regWrite, id_memRead   : decode-stage control bits
//   flush                     : squash the instruction entering EX
//   fwdA_mem/fwdA_wb          : operand A selects (EX/MEM result / MEM/WB value)
//   fwdB_mem/fwdB_wb          : operand B selects
//   stall                     : hold PC and IF/ID, bubble ID/EX
module forward_hazard_unit
    import forward_hazard_unit_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regWrite,
    input  logic             id_memRead,
    input  logic             flush,
    output logic             fwdA_mem,
    output logic             fwdA_wb,
    output logic             fwdB_mem,
    output logic             fwdB_wb,
    output logic             stall
);

    pipe_meta_t       idex, exmem, memwb;
    logic [REG_W-1:0] idex_rn, idex_rm;

    logic hit_a_mem, hit_a_wb, hit_b_mem, hit_b_wb;
    logic lu_rn, lu_rm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex    <= '0;
            exmem   <= '0;
            memwb   <= '0;
            idex_rn <= '0;
            idex_rm <= '0;
        end else begin
            memwb   <= exmem;
            exmem   <= idex;
            idex_rn <= id_rn;
            idex_rm <= id_rm;
            // A bubble keeps the indices but can never match as a producer
            // (regWrite=0) nor request forwarding as a consumer (valid=0).
            if (stall | flush) begin
                idex.valid    <= 1'b0;
                idex.rd       <= id_rd;
                idex.regWrite <= 1'b0;
                idex.memRead  <= 1'b0;
            end else begin
                idex.valid    <= id_valid;
                idex.rd       <= id_rd;
                idex.regWrite <= id_regWrite;
                idex.memRead  <= id_memRead;
            end
        end
    end

    fwd_compare u_cmp_a_mem (.meta(exmem), .src(idex_rn), .load_only(1'b0), .hit(hit_a_mem));
    fwd_compare u_cmp_a_wb  (.meta(memwb), .src(idex_rn), .load_only(1'b0), .hit(hit_a_wb));
    fwd_compare u_cmp_b_mem (.meta(exmem), .src(idex_rm), .load_only(1'b0), .hit(hit_b_mem));
    fwd_compare u_cmp_b_wb  (.meta(memwb), .src(idex_rm), .load_only(1'b0), .hit(hit_b_wb));

    // Load in ID/EX whose destination is read by the instruction in decode.
    fwd_compare u_cmp_lu_rn (.meta(idex), .src(id_rn), .load_only(1'b1), .hit(lu_rn));
    fwd_compare u_cmp_lu_rm (.meta(idex), .src(id_rm), .load_only(1'b1), .hit(lu_rm));

    // EX/MEM is the younger producer, so it wins; wb is masked by mem.
    assign fwdA_mem = hit_a_mem & idex.valid;
    assign fwdA_wb  = hit_a_wb  & idex.valid & ~fwdA_mem;
    assign fwdB_mem = hit_b_mem & idex.valid;
    assign fwdB_wb  = hit_b_wb  & idex.valid & ~fwdB_mem;

    assign stall = id_valid & (lu_rn | lu_rm);

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Scoreboard bench: the stimulus side predicts each cycle's selects from a
// record of which instruction entered EX on which cycle; a monitor compares
// on the falling edge.
module tb_forward_hazard_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rn = '0, id_rm = '0, id_rd = '0;
    logic       id_regWrite = 1'b0, id_memRead = 1'b0, flush = 1'b0;
    logic       fwdA_mem, fwdA_wb, fwdB_mem, fwdB_wb, stall;

    forward_hazard_unit dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
        .id_regWrite(id_regWrite), .id_memRead(id_memRead), .flush(flush),
        .fwdA_mem(fwdA_mem), .fwdA_wb(fwdA_wb), .fwdB_mem(fwdB_mem),
        .fwdB_wb(fwdB_wb), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit valid;
        int rd, rn, rm;
        bit regw, memr;
    } instr_t;

    typedef struct {
        logic [4:0] v;
        string      tag;
    } exp_t;

    exp_t   sb[$];
    int     tests = 0;
    int     fails = 0;
    int     cyc = 0;
    instr_t ex_at[int];   // instruction that entered EX on clock edge N

    function automatic instr_t mk(bit v, int rd, int rn, int rm, bit rw, bit mr);
        instr_t i;
        i.valid = v; i.rd = rd; i.rn = rn; i.rm = rm; i.regw = rw; i.memr = mr;
        return i;
    endfunction

    function automatic instr_t get(int c);
        if (ex_at.exists(c)) return ex_at[c];
        return mk(0, 0, 0, 0, 0, 0);
    endfunction

    // Producer p writes architectural register r (XZR is never written).
    function automatic bit writes(instr_t p, int r);
        return p.valid && p.regw && p.rd != 31 && p.rd == r;
    endfunction

    // {fwdA_mem, fwdA_wb, fwdB_mem, fwdB_wb, stall}
    function automatic logic [4:0] predict(instr_t id);
        instr_t ex, mem, wb;
        bit am, aw, bm, bw, st;
        ex  = get(cyc);
        mem = get(cyc - 1);
        wb  = get(cyc - 2);
        am = ex.valid && writes(mem, ex.rn);
        aw = ex.valid && writes(wb, ex.rn) && !am;
        bm = ex.valid && writes(mem, ex.rm);
        bw = ex.valid && writes(wb, ex.rm) && !bm;
        st = ex.memr && id.valid && (writes(ex, id.rn) || writes(ex, id.rm));
        return {am, aw, bm, bw, st};
    endfunction

    task automatic step(input instr_t ins, input bit fl, input string tag, output bit st);
        logic [4:0] e;
        exp_t x;
        id_valid = ins.valid; id_rd = 5'(ins.rd); id_rn = 5'(ins.rn); id_rm = 5'(ins.rm);
        id_regWrite = ins.regw; id_memRead = ins.memr; flush = fl;
        e = predict(ins);
        st = e[0];
        x.v = e; x.tag = tag;
        sb.push_back(x);
        @(posedge clk);
        cyc++;
        if (ins.valid && !st && !fl) ex_at[cyc] = ins;
        else ex_at[cyc] = mk(0, 0, 0, 0, 0, 0);
        #1;
    endtask

    // Upstream holds decode while stalled, unless it is being flushed.
    task automatic issue(input instr_t ins, input bit fl, input string tag);
        bit st;
        int n;
        n = 0;
        step(ins, fl, tag, st);
        while (st && !fl && n < 4) begin
            step(ins, fl, {tag, "_held"}, st);
            n++;
        end
    endtask

    task automatic nops(input int n, input string tag);
        for (int k = 0; k < n; k++) issue(mk(0, 0, 0, 0, 0, 0), 0, tag);
    endtask

    task automatic pulse_reset(input string tag);
        exp_t x;
        reset = 1'b1;
        #1;
        tests++;
        if ({fwdA_mem, fwdA_wb, fwdB_mem, fwdB_wb, stall} !== 5'b0) begin
            fails++;
            $display("FAIL %s_immediate: got %b expected 00000", tag,
                     {fwdA_mem, fwdA_wb, fwdB_mem, fwdB_wb, stall});
        end
        ex_at.delete();
        cyc = 0;
        x.v = 5'b0; x.tag = tag;
        sb.push_back(x);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    initial begin
        exp_t x;
        logic [4:0] got;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                x = sb.pop_front();
                got = {fwdA_mem, fwdA_wb, fwdB_mem, fwdB_wb, stall};
                tests++;
                if (got !== x.v) begin
                    fails++;
                    $display("FAIL %s (cyc %0d): got {aM,aW,bM,bW,st}=%b expected %b",
                             x.tag, cyc, got, x.v);
                end
            end
        end
    end

    function automatic int rreg();
        case ($urandom_range(0, 3))
            0: return 1;
            1: return 2;
            2: return 3;
            default: return 31;
        endcase
    endfunction

    initial begin
        instr_t r;
        bit mr;
        #2;
        tests++;
        if ({fwdA_mem, fwdA_wb, fwdB_mem, fwdB_wb, stall} !== 5'b0) begin
            fails++;
            $display("FAIL reset_state: got %b expected 00000",
                     {fwdA_mem, fwdA_wb, fwdB_mem, fwdB_wb, stall});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        // ADD X1,X2,X3 ; SUB X4,X1,X5
        issue(mk(1, 1, 2, 3, 1, 0), 0, "add_x1");
        issue(mk(1, 4, 1, 5, 1, 0), 0, "sub_use_x1");
        nops(3, "t1_sub_ex");
        // ADD X1 ; unrelated ; ORR X6,X7,X1
        issue(mk(1, 1, 2, 3, 1, 0), 0, "add_x1");
        issue(mk(1, 10, 11, 12, 1, 0), 0, "unrelated");
        issue(mk(1, 6, 7, 1, 1, 0), 0, "orr_use_x1");
        nops(3, "t2_orr_ex");
        // ADD X1 ; ADD X1 ; AND X9,X1,X1
        issue(mk(1, 1, 2, 3, 1, 0), 0, "add_x1_a");
        issue(mk(1, 1, 2, 3, 1, 0), 0, "add_x1_b");
        issue(mk(1, 9, 1, 1, 1, 0), 0, "and_use_x1");
        nops(3, "t3_and_ex");
        // LDUR X2,[X0] ; ADD X3,X2,X4
        issue(mk(1, 2, 0, 0, 1, 1), 0, "ldur_x2");
        issue(mk(1, 3, 2, 4, 1, 0), 0, "add_use_x2");
        nops(3, "t4_add_ex");
        // XZR destinations
        issue(mk(1, 31, 2, 31, 1, 0), 0, "addi_x31");
        issue(mk(1, 5, 31, 31, 1, 0), 0, "add_use_x31");
        nops(3, "t5_xzr_ex");
        issue(mk(1, 31, 0, 0, 1, 1), 0, "ldur_x31");
        issue(mk(1, 5, 31, 31, 1, 0), 0, "use_ld_x31");
        nops(3, "t5_ldxzr_ex");
        // flush together with load-use
        issue(mk(1, 2, 0, 0, 1, 1), 0, "ldur_x2_fl");
        issue(mk(1, 3, 2, 4, 1, 0), 1, "flush_loaduse");
        nops(3, "t6_after_flush");
        // reset while a forward is active
        issue(mk(1, 1, 2, 3, 1, 0), 0, "add_x1_r");
        issue(mk(1, 4, 1, 5, 1, 0), 0, "sub_use_x1_r");
        pulse_reset("reset_midstream");
        issue(mk(1, 4, 1, 5, 1, 0), 0, "post_reset_use");
        nops(3, "t7_post_reset");

        for (int i = 0; i < 400; i++) begin
            if (i == 200) pulse_reset("reset_random");
            mr = ($urandom_range(0, 3) == 0);
            r = mk($urandom_range(0, 7) != 0, rreg(), rreg(), rreg(),
                   mr ? 1'b1 : ($urandom_range(0, 3) != 0), mr);
            issue(r, $urandom_range(0, 7) == 0, "random");
        end
        nops(3, "drain");

        @(negedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
